// File: rtl/msrv32_alu_ctrl_stage.sv
// msrv32_alu_ctrl_stage
// Registered decode/control stage between fetch and the register-file/ALU
// operand muxes. An RV32I instruction and its PC are accepted over a
// valid/ready handshake, decoded combinationally, and held in a single
// pipeline register that supports stall and flush. A saturating counter
// tracks how many illegal instructions were accepted.
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   instr_in, pc_in           instruction word and its PC
//   in_valid_in/in_ready_out  upstream handshake
//   flush_in                  drop the held and the incoming instruction
//   out_valid_out/out_ready_in downstream handshake
//   alu_opcode_out            4-bit ALU opcode
//   op1_sel_out               00 rs1, 01 pc, 10 zero
//   op2_sel_out               0 rs2, 1 imm
//   imm_out                   sign-extended immediate
//   rs1/rs2/rd_addr_out       raw register address fields
//   rd_wr_en_out              instruction writes rd
//   pc_out                    PC of the held instruction
//   illegal_out               held instruction is not decodable
//   illegal_cnt_out           saturating count of accepted illegal instructions
module msrv32_alu_ctrl_stage (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        in_valid_in,
    output logic        in_ready_out,
    input  logic        flush_in,
    input  logic        out_ready_in,
    output logic        out_valid_out,
    output logic [3:0]  alu_opcode_out,
    output logic [1:0]  op1_sel_out,
    output logic        op2_sel_out,
    output logic [31:0] imm_out,
    output logic [4:0]  rs1_addr_out,
    output logic [4:0]  rs2_addr_out,
    output logic [4:0]  rd_addr_out,
    output logic        rd_wr_en_out,
    output logic [31:0] pc_out,
    output logic        illegal_out,
    output logic [7:0]  illegal_cnt_out
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [1:0] OP1_RS1  = 2'b00;
    localparam logic [1:0] OP1_PC   = 2'b01;
    localparam logic [1:0] OP1_ZERO = 2'b10;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u;

    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];
    assign imm_i  = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s  = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b  = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                     instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u  = {instr_in[31:12], 12'h000};

    logic [3:0]  opcode_d;
    logic [1:0]  op1_d;
    logic        op2_d;
    logic [31:0] imm_d;
    logic        wr_d;
    logic        illegal_d;

    always_comb begin
        opcode_d  = ALU_ADD;
        op1_d     = OP1_RS1;
        op2_d     = 1'b0;
        imm_d     = 32'h0;
        wr_d      = 1'b0;
        illegal_d = 1'b0;
        case (instr_in[6:0])
            OPC_OP: begin
                wr_d     = 1'b1;
                opcode_d = {instr_in[30], funct3};
                // Only SUB and SRA may set funct7[5]; anything else is reserved.
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    illegal_d = 1'b1;
            end
            OPC_OP_IMM: begin
                wr_d  = 1'b1;
                op2_d = 1'b1;
                imm_d = imm_i;
                case (funct3)
                    3'b001: begin
                        opcode_d = ALU_SLL;
                        if (funct7 != 7'b0000000) illegal_d = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000)      opcode_d = ALU_SRL;
                        else if (funct7 == 7'b0100000) opcode_d = ALU_SRA;
                        else                           illegal_d = 1'b1;
                    end
                    default: opcode_d = {1'b0, funct3};
                endcase
            end
            OPC_LUI: begin
                op1_d = OP1_ZERO;
                op2_d = 1'b1;
                imm_d = imm_u;
                wr_d  = 1'b1;
            end
            OPC_AUIPC: begin
                op1_d = OP1_PC;
                op2_d = 1'b1;
                imm_d = imm_u;
                wr_d  = 1'b1;
            end
            OPC_LOAD: begin
                op2_d = 1'b1;
                imm_d = imm_i;
                wr_d  = 1'b1;
            end
            OPC_STORE: begin
                op2_d = 1'b1;
                imm_d = imm_s;
            end
            OPC_BRANCH: begin
                imm_d = imm_b;
                case (funct3)
                    3'b000, 3'b001: opcode_d = ALU_SUB;
                    3'b100, 3'b101: opcode_d = ALU_SLT;
                    3'b110, 3'b111: opcode_d = ALU_SLTU;
                    default:        illegal_d = 1'b1;
                endcase
            end
            default: illegal_d = 1'b1;
        endcase
        // Illegal instructions present a harmless "0 + 0, no write" to the ALU.
        if (illegal_d) begin
            opcode_d = ALU_ADD;
            op1_d    = OP1_ZERO;
            op2_d    = 1'b0;
            imm_d    = 32'h0;
            wr_d     = 1'b0;
        end
    end

    logic        vld_p0;
    logic [3:0]  opcode_p0;
    logic [1:0]  op1_p0;
    logic        op2_p0;
    logic [31:0] imm_p0;
    logic [4:0]  rs1_p0, rs2_p0, rd_p0;
    logic        wr_p0;
    logic [31:0] pc_p0;
    logic        illegal_p0;
    logic [7:0]  cnt_p0;
    logic        capture;

    assign in_ready_out = !vld_p0 || out_ready_in;
    assign capture      = in_valid_in && in_ready_out && !flush_in;

    // Stage 0 register: flush has priority, then capture, then drain.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p0     <= 1'b0;
            opcode_p0  <= 4'h0;
            op1_p0     <= 2'b00;
            op2_p0     <= 1'b0;
            imm_p0     <= 32'h0;
            rs1_p0     <= 5'h0;
            rs2_p0     <= 5'h0;
            rd_p0      <= 5'h0;
            wr_p0      <= 1'b0;
            pc_p0      <= 32'h0;
            illegal_p0 <= 1'b0;
            cnt_p0     <= 8'h0;
        end else if (flush_in) begin
            vld_p0 <= 1'b0;
        end else if (capture) begin
            vld_p0     <= 1'b1;
            opcode_p0  <= opcode_d;
            op1_p0     <= op1_d;
            op2_p0     <= op2_d;
            imm_p0     <= imm_d;
            rs1_p0     <= instr_in[19:15];
            rs2_p0     <= instr_in[24:20];
            rd_p0      <= instr_in[11:7];
            wr_p0      <= wr_d;
            pc_p0      <= pc_in;
            illegal_p0 <= illegal_d;
            if (illegal_d && cnt_p0 != 8'hFF)
                cnt_p0 <= cnt_p0 + 8'd1;
        end else if (out_ready_in) begin
            vld_p0 <= 1'b0;
        end
    end

    assign out_valid_out   = vld_p0;
    assign alu_opcode_out  = opcode_p0;
    assign op1_sel_out     = op1_p0;
    assign op2_sel_out     = op2_p0;
    assign imm_out         = imm_p0;
    assign rs1_addr_out    = rs1_p0;
    assign rs2_addr_out    = rs2_p0;
    assign rd_addr_out     = rd_p0;
    assign rd_wr_en_out    = wr_p0;
    assign pc_out          = pc_p0;
    assign illegal_out     = illegal_p0;
    assign illegal_cnt_out = cnt_p0;

endmodule

// File: tb/tb_msrv32_alu_ctrl_stage.sv
// Testbench for msrv32_alu_ctrl_stage: directed vectors, a reference model
// of the stage checked every cycle, and literal spot checks.
module tb_msrv32_alu_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [3:0]  alu_opcode;
    logic [1:0]  op1_sel;
    logic        op2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_wr_en;
    logic [31:0] pc_o;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    msrv32_alu_ctrl_stage dut (
        .clk_in(clk), .rst_n_in(rst_n), .instr_in(instr), .pc_in(pc),
        .in_valid_in(in_valid), .in_ready_out(in_ready), .flush_in(flush),
        .out_ready_in(out_ready), .out_valid_out(out_valid),
        .alu_opcode_out(alu_opcode), .op1_sel_out(op1_sel), .op2_sel_out(op2_sel),
        .imm_out(imm), .rs1_addr_out(rs1_addr), .rs2_addr_out(rs2_addr),
        .rd_addr_out(rd_addr), .rd_wr_en_out(rd_wr_en), .pc_out(pc_o),
        .illegal_out(illegal), .illegal_cnt_out(illegal_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0]  opc;
        logic [1:0]  op1;
        logic        op2;
        logic [31:0] imm;
        logic        wr;
        logic        ill;
    } dec_t;

    // What the stage must present for one instruction word, by instruction class.
    function automatic dec_t model(input logic [31:0] i);
        dec_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] ii, si, bi, ui;
        f3 = i[14:12];
        f7 = i[31:25];
        ii = {{20{i[31]}}, i[31:20]};
        si = {{20{i[31]}}, i[31:25], i[11:7]};
        bi = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        ui = {i[31:12], 12'h000};
        d = '{opc: 4'h0, op1: 2'b10, op2: 1'b0, imm: 32'h0, wr: 1'b0, ill: 1'b1};
        unique case (1'b1)
            i[6:0] == 7'h33:
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
                    d = '{opc: {f7[5], f3}, op1: 2'b00, op2: 1'b0, imm: 32'h0, wr: 1'b1, ill: 1'b0};
            i[6:0] == 7'h13:
                if (f3 == 3'd1 && f7 == 7'h00)
                    d = '{opc: 4'b0001, op1: 2'b00, op2: 1'b1, imm: ii, wr: 1'b1, ill: 1'b0};
                else if (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20))
                    d = '{opc: (f7 == 7'h20) ? 4'b1101 : 4'b0101, op1: 2'b00, op2: 1'b1,
                          imm: ii, wr: 1'b1, ill: 1'b0};
                else if (f3 != 3'd1 && f3 != 3'd5)
                    d = '{opc: {1'b0, f3}, op1: 2'b00, op2: 1'b1, imm: ii, wr: 1'b1, ill: 1'b0};
            i[6:0] == 7'h37:
                d = '{opc: 4'h0, op1: 2'b10, op2: 1'b1, imm: ui, wr: 1'b1, ill: 1'b0};
            i[6:0] == 7'h17:
                d = '{opc: 4'h0, op1: 2'b01, op2: 1'b1, imm: ui, wr: 1'b1, ill: 1'b0};
            i[6:0] == 7'h03:
                d = '{opc: 4'h0, op1: 2'b00, op2: 1'b1, imm: ii, wr: 1'b1, ill: 1'b0};
            i[6:0] == 7'h23:
                d = '{opc: 4'h0, op1: 2'b00, op2: 1'b1, imm: si, wr: 1'b0, ill: 1'b0};
            i[6:0] == 7'h63:
                if (f3 == 3'd0 || f3 == 3'd1)
                    d = '{opc: 4'b1000, op1: 2'b00, op2: 1'b0, imm: bi, wr: 1'b0, ill: 1'b0};
                else if (f3 == 3'd4 || f3 == 3'd5)
                    d = '{opc: 4'b0010, op1: 2'b00, op2: 1'b0, imm: bi, wr: 1'b0, ill: 1'b0};
                else if (f3 == 3'd6 || f3 == 3'd7)
                    d = '{opc: 4'b0011, op1: 2'b00, op2: 1'b0, imm: bi, wr: 1'b0, ill: 1'b0};
            default: ;
        endcase
        return d;
    endfunction

    // Model state: the instruction held in the stage, and the illegal count.
    logic        m_vld = 1'b0;
    logic        m_fresh = 1'b1;
    dec_t        m_d = '0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_word = 32'h0;
    int          m_cnt = 0;
    logic        m_rdy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld = 1'b0; m_fresh = 1'b1; m_d = '0; m_pc = 32'h0; m_word = 32'h0; m_cnt = 0;
        end else begin
            m_rdy = !m_vld || out_ready;
            if (flush) begin
                m_vld = 1'b0;
            end else if (in_valid && m_rdy) begin
                m_vld = 1'b1; m_fresh = 1'b0;
                m_d = model(instr); m_pc = pc; m_word = instr;
                if (m_d.ill && m_cnt < 255) m_cnt++;
            end else if (out_ready) begin
                m_vld = 1'b0;
            end
        end
        #1;
        chk("out_valid", {31'h0, out_valid}, {31'h0, m_vld});
        chk("in_ready", {31'h0, in_ready}, {31'h0, (!m_vld || out_ready)});
        chk("illegal_cnt", {24'h0, illegal_cnt}, m_cnt);
        if (m_vld || m_fresh) begin
            chk("alu_opcode", {28'h0, alu_opcode}, {28'h0, m_d.opc});
            chk("op1_sel", {30'h0, op1_sel}, {30'h0, m_d.op1});
            chk("op2_sel", {31'h0, op2_sel}, {31'h0, m_d.op2});
            chk("imm", imm, m_d.imm);
            chk("rd_wr_en", {31'h0, rd_wr_en}, {31'h0, m_d.wr});
            chk("illegal", {31'h0, illegal}, {31'h0, m_d.ill});
            chk("pc_out", pc_o, m_pc);
            chk("rs1", {27'h0, rs1_addr}, {27'h0, m_word[19:15]});
            chk("rs2", {27'h0, rs2_addr}, {27'h0, m_word[24:20]});
            chk("rd", {27'h0, rd_addr}, {27'h0, m_word[11:7]});
        end
    end

    task automatic push(input logic [31:0] w, input logic [31:0] p);
        instr = w; pc = p; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [31:0] mix [15] = '{
        32'h002081B3, 32'h007372B3, 32'hFFF0B093, 32'h00309093, 32'h02309093,
        32'h0030D093, 32'h80000097, 32'hFFC42503, 32'hFEA42E23, 32'hFE208EE3,
        32'h0020C463, 32'h0020E463, 32'h0020A463, 32'h40208033, 32'h40209033
    };
    logic [31:0] strm [4] = '{32'h00A00093, 32'h00B00113, 32'h00C00193, 32'h00D00213};
    int held_cnt;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst illegal_cnt", {24'h0, illegal_cnt}, 32'h0);
        chk("rst in_ready", {31'h0, in_ready}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // Literal decodes
        push(32'h40B50533, 32'h100);
        chk("sub opcode", {28'h0, alu_opcode}, 32'h8);
        chk("sub op1", {30'h0, op1_sel}, 32'h0);
        chk("sub op2", {31'h0, op2_sel}, 32'h0);
        chk("sub rd", {27'h0, rd_addr}, 32'd10);
        chk("sub rs1", {27'h0, rs1_addr}, 32'd10);
        chk("sub rs2", {27'h0, rs2_addr}, 32'd11);
        chk("sub wr", {31'h0, rd_wr_en}, 32'h1);
        chk("sub pc", pc_o, 32'h100);
        push(32'h4025D593, 32'h104);
        chk("srai opcode", {28'h0, alu_opcode}, 32'hD);
        chk("srai op2", {31'h0, op2_sel}, 32'h1);
        chk("srai imm", imm, 32'h00000402);
        push(32'h12345537, 32'h108);
        chk("lui opcode", {28'h0, alu_opcode}, 32'h0);
        chk("lui op1", {30'h0, op1_sel}, 32'h2);
        chk("lui imm", imm, 32'h12345000);

        // Illegal instructions
        push(32'h0000000F, 32'h10C);
        chk("fence illegal", {31'h0, illegal}, 32'h1);
        push(32'h02000033, 32'h110);
        chk("funct7 illegal", {31'h0, illegal}, 32'h1);
        chk("illegal_cnt 2", {24'h0, illegal_cnt}, 32'd2);

        // Mixed decode coverage
        for (int k = 0; k < 15; k++) push(mix[k], 32'h200 + 32'(k * 4));
        @(negedge clk);

        // Back-to-back stream with a 3-cycle stall after the first
        instr = strm[0]; pc = 32'h300; in_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; instr = strm[1]; pc = 32'h304;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall in_ready", {31'h0, in_ready}, 32'h0);
            chk("stall pc held", pc_o, 32'h300);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stream pc1", pc_o, 32'h304);
        instr = strm[2]; pc = 32'h308;
        @(negedge clk);
        instr = strm[3]; pc = 32'h30C;
        @(negedge clk);
        in_valid = 1'b0;
        chk("stream pc3", pc_o, 32'h30C);
        @(negedge clk);

        // Flush while an output is held
        out_ready = 1'b0;
        push(32'h002081B3, 32'h400);
        held_cnt = m_cnt;
        flush = 1'b1; in_valid = 1'b1; instr = 32'h0000000F;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", {31'h0, out_valid}, 32'h0);
        chk("flush cnt", {24'h0, illegal_cnt}, held_cnt);
        out_ready = 1'b1;
        @(negedge clk);

        // Saturation
        instr = 32'h0; pc = 32'h500; in_valid = 1'b1;
        repeat (300) @(negedge clk);
        in_valid = 1'b0;
        chk("cnt saturate", {24'h0, illegal_cnt}, 32'd255);
        @(negedge clk);

        // Reset mid-stall
        out_ready = 1'b0;
        push(32'h40B50533, 32'h600);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst cnt", {24'h0, illegal_cnt}, 32'h0);
        chk("midrst pc", pc_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/msrv32_alu_ctrl_stage.md
# msrv32_alu_ctrl_stage

Registered decode/control stage that drives the msrv32 ALU. It accepts a fetched 32-bit RV32I instruction and its PC over a valid/ready handshake, and decodes the 4-bit ALU opcode, operand selects, register addresses and immediate. The result is held in one pipeline register with stall and flush support, and an illegal-instruction counter is kept. It sits between fetch and the register-file/ALU operand muxes.

## Interface
- No parameters.
- clk_in  input  1  single clock, all state rises on posedge.
- rst_n_in  input  1  asynchronous, active-low reset.
- instr_in  input  32  instruction word.
- pc_in  input  32  PC of instr_in.
- in_valid_in  input  1  instr_in/pc_in valid.
- in_ready_out  output  1  stage can accept this cycle.
- flush_in  input  1  discard held and incoming instruction.
- out_ready_in  input  1  downstream accepts this cycle.
- out_valid_out  output  1  registered outputs valid.
- alu_opcode_out  output  4  ALU opcode: ADD 0000, SUB 1000, SLT 0010, SLTU 0011, XOR 0100, OR 0110, AND 0111, SLL 0001, SRL 0101, SRA 1101.
- op1_sel_out  output  2  00 rs1, 01 pc, 10 zero.
- op2_sel_out  output  1  0 rs2, 1 imm.
- imm_out  output  32  sign-extended immediate.
- rs1_addr_out, rs2_addr_out, rd_addr_out  output  5 each  register addresses.
- rd_wr_en_out  output  1  instruction writes rd.
- pc_out  output  32  registered pc_in.
- illegal_out  output  1  instruction not decodable.
- illegal_cnt_out  output  8  saturating count of illegal instructions accepted.

## Operation
- Decode is combinational on instr_in; only registered values reach outputs.
- OP (0110011): opcode {instr[30], funct3}; op1 rs1, op2 rs2, wr_en 1. Legal only if funct7 = 0000000, or funct7 = 0100000 with funct3 000/101.
- OP-IMM (0010011): op2 imm (I-type), wr_en 1. funct3 001: funct7 must be 0, opcode 0001. funct3 101: funct7 0000000 → 0101, 0100000 → 1101, else illegal. Other funct3: opcode {0, funct3}.
- LUI (0110111): ADD, op1 zero, op2 U-imm (instr[31:12]<<12), wr_en 1.
- AUIPC (0010111): ADD, op1 pc, op2 U-imm, wr_en 1.
- LOAD (0000011): ADD, rs1 + I-imm, wr_en 1. STORE (0100011): ADD, rs1 + S-imm, wr_en 0.
- BRANCH (1100011): op1 rs1, op2 rs2, wr_en 0, imm B-type. funct3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU; 010/011 illegal.
- Anything else, including instr[1:0] ≠ 11: illegal.
- Illegal instruction: opcode 0000, op1_sel 10, op2_sel 0, imm 0, wr_en 0, illegal 1. Addresses still pass through raw fields.
- Capture when in_valid_in & in_ready_out & !flush_in. illegal_cnt increments on an illegal capture and saturates at 255.

## Timing
- Reset (async assert, sync release): out_valid 0, every data output 0, illegal_cnt 0.
- Latency: 1 cycle from capture to out_valid_out.
- in_ready_out = !out_valid_out | out_ready_in (combinational; full-throughput, no bubble).
- out_valid holds, and outputs stay stable, while out_ready_in is 0.
- flush_in: next cycle out_valid 0. The input is not captured that cycle. flush wins over every simultaneous event. The counter does not increment for a flushed instruction.
- Simultaneous output accept and input capture: new data replaces old in the same edge.
- Reset mid-stall: outputs are dropped immediately and the counter is cleared.

## Test plan
- Reset: hold rst_n_in 0 → out_valid 0, illegal_cnt 0, in_ready 1.
- instr 0x40B50533 (sub a0,a0,a1), pc 0x100 → next cycle alu_opcode 1000, op1_sel 00, op2_sel 0, rd 10, rs1 10, rs2 11, wr_en 1, pc_out 0x100.
- instr 0x4025D593 (srai a1,a1,2) → opcode 1101, op2_sel 1, imm 0x00000402 (raw I-field, which includes funct7 bits). instr 0x12345537 (lui) → opcode 0000, op1_sel 10, imm 0x12345000.
- Back-to-back stream of 4 instructions, out_ready held 0 for 3 cycles after the first → first output held stable, in_ready 0, no loss or duplication, order preserved.
- instr 0x0000000F, then 0x02000033 (funct7 0000001) → illegal 1 both, illegal_cnt 2. 300 illegal captures → count 255.
- flush_in asserted with in_valid 1 while an output is held → next cycle out_valid 0, counter unchanged.
